// File: rtl/game_pkg.sv
// Shared definitions for the game logic: level one-hot codes, the
// level-to-length mapping, the answer recorder state type and two small
// helpers that examine the 8-bit press-event vector.
package game_pkg;

    localparam logic [2:0] LV1 = 3'b001;
    localparam logic [2:0] LV2 = 3'b010;
    localparam logic [2:0] LV3 = 3'b100;

    localparam int NUM_BTN = 8;
    localparam int COUNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } rec_state_t;

    // Answer length for a one-hot level; 0 marks an invalid level code.
    function automatic logic [COUNT_W-1:0] level_to_len(input logic [2:0] lvl);
        case (lvl)
            LV1:     return 5'd8;
            LV2:     return 5'd12;
            LV3:     return 5'd16;
            default: return 5'd0;
        endcase
    endfunction

    // Number of buttons that produced a press event this cycle.
    function automatic logic [3:0] count_presses(input logic [NUM_BTN-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [2:0] press_index(input logic [NUM_BTN-1:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int i = NUM_BTN - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input path: 2-FF synchroniser, stability counter that
// accepts a new level after DB_CYCLES consecutive disagreeing samples, and a
// one-cycle press pulse on each rising edge of the accepted level.
module btn_debounce #(
    parameter int DB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             level_d_reg;
    logic [CNT_W-1:0] cnt_reg;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any
    // agreeing sample restarts the count, so short bounces never get through.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_reg <= 1'b0;
            cnt_reg   <= '0;
        end else if (sync2_reg == level_reg) begin
            cnt_reg <= '0;
        end else if (cnt_reg == CNT_W'(DB_CYCLES - 1)) begin
            level_reg <= sync2_reg;
            cnt_reg   <= '0;
        end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Delayed copy of the accepted level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            level_d_reg <= 1'b0;
        end else begin
            level_d_reg <= level_reg;
        end
    end

    assign level = level_reg;
    assign press = level_reg & ~level_d_reg;

endmodule

// File: rtl/button_seq_recorder.sv
// Records the player's answer as a sequence of 3-bit button indices.
// Eight debounced buttons feed a four-state controller (IDLE, ARMED,
// CAPTURE, DONE) that writes one entry per clean single press until the
// level-dependent length is reached.
// Build option: define BUTTON_ECHO_LED_EN to drive echo_led with the
// debounced button levels during CAPTURE; otherwise echo_led is tied low.
module button_seq_recorder
    import game_pkg::*;
#(
    parameter int MAX_LEN   = 16,
    parameter int IDX_W     = 3,
    parameter int DB_CYCLES = 20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [2:0]               level,
    input  logic [NUM_BTN-1:0]       buttons,
    output logic [MAX_LEN*IDX_W-1:0] seq,
    output logic [COUNT_W-1:0]       count,
    output logic                     done,
    output logic                     multi_err,
    output logic [NUM_BTN-1:0]       echo_led
);

    rec_state_t state_reg;
    rec_state_t state_next;

    logic [NUM_BTN-1:0] level_vec;
    logic [NUM_BTN-1:0] press_vec;
    logic [3:0]         press_cnt;
    logic [2:0]         press_idx;

    logic [COUNT_W-1:0] count_reg;
    logic [COUNT_W-1:0] target_reg;
    logic               multi_err_reg;
    logic [IDX_W-1:0]   entry_reg [MAX_LEN];

    logic write_en;
    logic multi_hit;
    logic clear_all;

    // ------------------------------------------------------------------
    // Input path: one debouncer per button
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            btn_debounce #(
                .DB_CYCLES(DB_CYCLES)
            ) u_btn (
                .clk   (clk),
                .rst   (rst),
                .raw   (buttons[gi]),
                .level (level_vec[gi]),
                .press (press_vec[gi])
            );
        end
    endgenerate

    assign press_cnt = count_presses(press_vec);
    assign press_idx = press_index(press_vec);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; dropping enable returns to IDLE from anywhere.
    always_comb begin
        state_next = state_reg;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (level_to_len(level) != '0) begin
                        state_next = ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    // Buttons held from before the round must be released first.
                    if (level_vec == '0) begin
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (write_en && (count_reg + COUNT_W'(1) == target_reg)) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_next = ST_DONE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Output/strobe logic derived from the current state.
    always_comb begin
        write_en  = 1'b0;
        multi_hit = 1'b0;
        done      = 1'b0;
        echo_led  = '0;
        case (state_reg)
            ST_CAPTURE: begin
                write_en  = (press_cnt == 4'd1) && (count_reg < COUNT_W'(MAX_LEN));
                multi_hit = (press_cnt >= 4'd2);
`ifdef BUTTON_ECHO_LED_EN
                echo_led  = level_vec;
`endif
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                write_en = 1'b0;
            end
        endcase
    end

    // Any transition into IDLE wipes the recorded answer.
    assign clear_all = (state_next == ST_IDLE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------

    // Count, latched target length and sticky multi-press flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg     <= '0;
            target_reg    <= '0;
            multi_err_reg <= 1'b0;
        end else if (clear_all) begin
            count_reg     <= '0;
            multi_err_reg <= 1'b0;
        end else begin
            // Leaving IDLE is the only moment the level is looked at.
            if (state_reg == ST_IDLE) begin
                target_reg <= level_to_len(level);
            end
            if (write_en) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
            if (multi_hit) begin
                multi_err_reg <= 1'b1;
            end
        end
    end

    // Sequence store: entry gi takes the press index when it is the next slot.
    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_entry
            // Entry write/clear.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    entry_reg[gi] <= '0;
                end else if (clear_all) begin
                    entry_reg[gi] <= '0;
                end else if (write_en && (count_reg == COUNT_W'(gi))) begin
                    entry_reg[gi] <= IDX_W'(press_idx);
                end
            end

            assign seq[gi*IDX_W +: IDX_W] = entry_reg[gi];
        end
    endgenerate

    assign count     = count_reg;
    assign multi_err = multi_err_reg;

endmodule

// File: tb/tb_button_seq_recorder.sv
// Self-checking bench for button_seq_recorder. A behavioural model (sample
// windows for debouncing, a queue of recorded indices for the answer) is
// advanced on every clock edge and compared against the DUT on every falling
// edge; a few literal expectations pin the directed scenarios.
module tb_button_seq_recorder;

    localparam int MAX_LEN = 16;
    localparam int IDX_W   = 3;
    localparam int DB      = 20;
    localparam int SEQ_W   = MAX_LEN * IDX_W;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [2:0]       level;
    logic [7:0]       buttons;
    logic [SEQ_W-1:0] seq;
    logic [4:0]       count;
    logic             done;
    logic             multi_err;
    logic [7:0]       echo_led;

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 0;

    button_seq_recorder #(
        .MAX_LEN(MAX_LEN),
        .IDX_W(IDX_W),
        .DB_CYCLES(DB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .level(level),
        .buttons(buttons),
        .seq(seq),
        .count(count),
        .done(done),
        .multi_err(multi_err),
        .echo_led(echo_led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_q[$];      // recorded answer indices, in order
    int          m_phase;     // 0 idle, 1 waiting for release, 2 capturing, 3 complete
    int          m_target;
    bit          m_merr;
    logic [7:0]  m_d1, m_d2;  // raw buttons as seen one and two edges ago
    logic [7:0]  m_lv;        // accepted (debounced) levels
    logic [7:0]  m_pend;      // levels that rose on the previous edge
    logic [DB-1:0] m_win [8]; // last DB synchronised samples per button

    function automatic int len_of(input logic [2:0] l);
        if (l == 3'b001) return 8;
        if (l == 3'b010) return 12;
        if (l == 3'b100) return 16;
        return 0;
    endfunction

    function automatic logic [SEQ_W-1:0] model_seq();
        logic [SEQ_W-1:0] s;
        s = '0;
        for (int k = 0; k < m_q.size(); k++) s[k*IDX_W +: IDX_W] = IDX_W'(m_q[k]);
        return s;
    endfunction

    always @(posedge clk) begin
        logic [7:0] nl;
        int np;
        if (!rst) begin
            m_phase = 0; m_q.delete(); m_merr = 0; m_target = 0;
            m_d1 = '0; m_d2 = '0; m_lv = '0; m_pend = '0;
            for (int b = 0; b < 8; b++) m_win[b] = '0;
        end else begin
            if (!enable) begin
                m_phase = 0; m_q.delete(); m_merr = 0;
            end else begin
                np = $countones(m_pend);
                case (m_phase)
                    0: if (len_of(level) != 0) begin m_target = len_of(level); m_phase = 1; end
                    1: if (m_lv == 8'h00) m_phase = 2;
                    2: begin
                        if (np == 1 && m_q.size() < MAX_LEN) begin
                            for (int b = 0; b < 8; b++) if (m_pend[b]) m_q.push_back(b);
                            if (m_q.size() == m_target) m_phase = 3;
                        end else if (np >= 2) begin
                            m_merr = 1;
                        end
                    end
                    default: ;
                endcase
            end
            // A level is accepted once DB consecutive synchronised samples agree.
            nl = m_lv;
            for (int b = 0; b < 8; b++) begin
                m_win[b] = {m_win[b][DB-2:0], m_d2[b]};
                if (&m_win[b]) nl[b] = 1'b1;
                else if (m_win[b] == '0) nl[b] = 1'b0;
            end
            m_pend = nl & ~m_lv;
            m_lv   = nl;
            m_d2   = m_d1;
            m_d1   = buttons;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            logic [7:0] exp_echo;
            exp_echo = 8'h00;
`ifdef BUTTON_ECHO_LED_EN
            if (m_phase == 2) exp_echo = m_lv;
`endif
            chk("cyc_count", 64'(count), 64'(m_q.size()));
            chk("cyc_done", 64'(done), 64'(m_phase == 3));
            chk("cyc_multi_err", 64'(multi_err), 64'(m_merr));
            chk("cyc_seq", 64'(seq), 64'(model_seq()));
            chk("cyc_echo", 64'(echo_led), 64'(exp_echo));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_btn(input int b, input int hold, input int gap, input bit bounce);
        int nb;
        nb = bounce ? int'($urandom_range(2, 5)) : 0;
        for (int i = 0; i < nb; i++) begin
            buttons[b] = 1'b1; step(int'($urandom_range(1, 8)));
            buttons[b] = 1'b0; step(int'($urandom_range(1, 8)));
        end
        buttons[b] = 1'b1; step(hold);
        buttons[b] = 1'b0; step(gap);
        $display("press btn=%0d hold=%0d bounces=%0d count=%0d", b, hold, nb, count);
    endtask

    int               idx_list[17];
    logic [SEQ_W-1:0] exp_pack;
    logic [2:0]       lvl_choice [5];

    initial begin
        rst = 1'b0; enable = 1'b0; level = 3'b001; buttons = '0;
        lvl_choice[0] = 3'b001; lvl_choice[1] = 3'b010; lvl_choice[2] = 3'b100;
        lvl_choice[3] = 3'b011; lvl_choice[4] = 3'b000;
        step(3);
        checking = 1;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_seq", 64'(seq), 64'd0);
        chk("reset_flags", 64'({done, multi_err, echo_led}), 64'd0);
        rst = 1'b1;
        step(2);

        // Level 1: eight clean presses.
        enable = 1'b1; level = 3'b001; step(3);
        idx_list[0] = 3; idx_list[1] = 0; idx_list[2] = 7; idx_list[3] = 1;
        idx_list[4] = 2; idx_list[5] = 6; idx_list[6] = 5; idx_list[7] = 4;
        for (int k = 0; k < 8; k++) press_btn(idx_list[k], 25, 25, 0);
        chk("lv1_count", 64'(count), 64'd8);
        chk("lv1_done", 64'(done), 64'd1);
        chk("lv1_seq_lo", 64'(seq[23:0]), 64'(24'o45621703));
        chk("lv1_seq_hi", 64'(seq[47:24]), 64'd0);

        // Level 3: sixteen presses, done only after the last, 17th ignored.
        enable = 1'b0; step(2);
        enable = 1'b1; level = 3'b100; step(3);
        exp_pack = '0;
        for (int k = 0; k < 16; k++) begin
            idx_list[k] = int'($urandom_range(0, 7));
            exp_pack[k*IDX_W +: IDX_W] = IDX_W'(idx_list[k]);
            if (k == 15) begin
                chk("lv3_count15", 64'(count), 64'd15);
                chk("lv3_done_early", 64'(done), 64'd0);
            end
            press_btn(idx_list[k], 25, 25, 0);
        end
        chk("lv3_count16", 64'(count), 64'd16);
        chk("lv3_done", 64'(done), 64'd1);
        chk("lv3_seq", 64'(seq), 64'(exp_pack));
        press_btn(int'($urandom_range(0, 7)), 25, 25, 0);
        chk("lv3_extra_count", 64'(count), 64'd16);
        chk("lv3_extra_seq", 64'(seq), 64'(exp_pack));

        // Button 2 held before enable, then a timed press.
        enable = 1'b0; buttons[2] = 1'b1; step(30);
        enable = 1'b1; level = 3'b001; step(40);
        chk("held_count", 64'(count), 64'd0);
        buttons[2] = 1'b0; step(30);
        buttons[2] = 1'b1; step(22);
        chk("latency_before", 64'(count), 64'd0);
        step(1);
        chk("latency_at", 64'(count), 64'd1);
        chk("held_entry0", 64'(seq[2:0]), 64'd2);
        buttons[2] = 1'b0; step(30);

        // Short glitch, then a bounce train settling high.
        buttons[4] = 1'b1; step(5); buttons[4] = 1'b0; step(40);
        chk("glitch_count", 64'(count), 64'd1);
        press_btn(4, 25, 30, 1);
        chk("bounce_count", 64'(count), 64'd2);
        chk("bounce_entry1", 64'(seq[5:3]), 64'd4);

        // Simultaneous presses on buttons 1 and 6.
        buttons = 8'h42; step(25); buttons = 8'h00; step(30);
        $display("press btn=1+6 hold=25 multi_err=%0d count=%0d", multi_err, count);
        chk("multi_err", 64'(multi_err), 64'd1);
        chk("multi_count", 64'(count), 64'd2);

        // Enable dropped after four entries.
        enable = 1'b0; step(1);
        enable = 1'b1; level = 3'b010; step(3);
        for (int k = 0; k < 4; k++) press_btn(k + 3, 22, 22, 0);
        chk("drop_pre_count", 64'(count), 64'd4);
        enable = 1'b0; step(1);
        chk("drop_count", 64'(count), 64'd0);
        chk("drop_seq", 64'(seq), 64'd0);

        // Reset in the middle of a capture.
        enable = 1'b1; level = 3'b001; step(3);
        press_btn(6, 25, 25, 0);
        press_btn(0, 25, 25, 0);
        buttons[5] = 1'b1; step(10);
        rst = 1'b0; step(1);
        chk("rst_mid_count", 64'(count), 64'd0);
        chk("rst_mid_seq", 64'(seq), 64'd0);
        chk("rst_mid_flags", 64'({done, multi_err, echo_led}), 64'd0);
        rst = 1'b1; buttons = '0; step(30);

        // Randomised traffic checked cycle by cycle against the model.
        level = 3'b100;
        for (int t = 0; t < 40; t++) begin
            int op;
            int b1;
            int b2;
            op = int'($urandom_range(0, 9));
            b1 = int'($urandom_range(0, 7));
            if (op <= 5) begin
                press_btn(b1, int'($urandom_range(DB, DB + 10)), int'($urandom_range(DB, DB + 10)), op[0]);
            end else if (op == 6) begin
                b2 = (b1 + int'($urandom_range(1, 7))) % 8;
                buttons[b1] = 1'b1; buttons[b2] = 1'b1; step(25);
                buttons = '0; step(25);
                $display("press btn=%0d+%0d multi_err=%0d count=%0d", b1, b2, multi_err, count);
            end else if (op == 7) begin
                buttons[b1] = 1'b1; step(int'($urandom_range(1, DB - 1)));
                buttons[b1] = 1'b0; step(25);
                $display("glitch btn=%0d count=%0d", b1, count);
            end else if (op == 8) begin
                enable = 1'b0; step(int'($urandom_range(1, 3)));
                level = lvl_choice[$urandom_range(0, 4)];
                enable = 1'b1; step(3);
                $display("restart level=%b count=%0d", level, count);
            end else begin
                rst = 1'b0; step(int'($urandom_range(1, 3)));
                rst = 1'b1; step(2);
                $display("reset pulse count=%0d", count);
            end
        end

        step(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
